// File: rtl/dmem_ctrl.sv
// dmem_ctrl: sequences CPU loads/stores onto a single-port, word-wide
// synchronous data memory. Byte stores are done as read-modify-write
// because the memory has no byte enables.
//
// Handshake: the CPU raises req with we/lb/addr/wdata. The request is taken
// only while the controller is idle (busy=0). busy stays high until the
// one-cycle ready pulse, and that pulse marks completion. rdata is valid
// from ready and is held until the next load completes.
module dmem_ctrl #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic              lb,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              ready,
    output logic              busy,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_din,
    input  logic [31:0]       mem_dout,
    output logic              mem_we
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        wdata_q;   // only the byte-store data needs holding
    logic              we_q;
    logic              lb_q;

    logic [7:0]        lane_byte;
    logic [31:0]       merged;

    // Strobes are decoded from state so that reset removes them at once.
    assign ready    = (state == DONE);
    assign busy     = (state != IDLE);
    assign mem_we   = (state == WR);
    assign mem_addr = addr_q[ADDR_W-1:2];

    // Select the addressed byte lane and build the merged sb write word.
    always_comb begin
        lane_byte = mem_dout[7:0];
        merged    = mem_dout;
        case (addr_q[1:0])
            2'd0: begin lane_byte = mem_dout[7:0];   merged[7:0]   = wdata_q; end
            2'd1: begin lane_byte = mem_dout[15:8];  merged[15:8]  = wdata_q; end
            2'd2: begin lane_byte = mem_dout[23:16]; merged[23:16] = wdata_q; end
            default: begin lane_byte = mem_dout[31:24]; merged[31:24] = wdata_q; end
        endcase
    end

    // Main sequencer: request latch, read capture, write data and state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            lb_q    <= 1'b0;
            rdata   <= '0;
            mem_din <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        addr_q  <= addr;
                        wdata_q <= wdata[7:0];
                        we_q    <= we;
                        lb_q    <= lb;
                        if (we && !lb) begin
                            mem_din <= wdata;
                            state   <= WR;
                        end else begin
                            state   <= RD;
                        end
                    end
                end
                RD: state <= CAP;
                CAP: begin
                    if (we_q) begin
                        mem_din <= merged;
                        state   <= WR;
                    end else begin
                        if (lb_q) rdata <= {{24{lane_byte[7]}}, lane_byte};
                        else      rdata <= mem_dout;
                        state <= DONE;
                    end
                end
                WR:      state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: synchronous word memory model plus directed
// load/store/reset/back-to-back sequences with hand-computed results.
module tb_dmem_ctrl;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req = 1'b0;
    logic              we = 1'b0;
    logic              lb = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic [31:0]       wdata = '0;
    logic [31:0]       rdata;
    logic              ready;
    logic              busy;
    logic [ADDR_W-3:0] mem_addr;
    logic [31:0]       mem_din;
    logic [31:0]       mem_dout;
    logic              mem_we;

    logic [31:0] mem [0:255];

    int checks = 0;
    int errors = 0;

    // results of the last run_op
    int          lat;
    int          busy_n;
    int          we_n;
    logic [31:0] we_addr;
    logic [31:0] we_din;

    // clock / reset block
    always #5 clk = ~clk;

    dmem_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .lb(lb), .addr(addr),
        .wdata(wdata), .rdata(rdata), .ready(ready), .busy(busy),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_we(mem_we)
    );

    // synchronous single-port memory: read data valid the cycle after address
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_din;
        mem_dout <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // driver: present one request, drop req after the accept edge, scramble
    // the other inputs while busy, and measure the operation until ready
    task automatic run_op(input logic w, input logic b, input logic [ADDR_W-1:0] a,
                          input logic [31:0] d);
        @(negedge clk);
        req = 1'b1; we = w; lb = b; addr = a; wdata = d;
        @(posedge clk);
        #1;
        req = 1'b0; we = ~w; lb = ~b; addr = ~a; wdata = ~d;
        lat = 0; busy_n = 0; we_n = 0; we_addr = '0; we_din = '0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (mem_we) begin
                we_n++;
                we_addr = 32'(mem_addr);
                we_din  = mem_din;
            end
            if (ready) begin
                lat = n;
                break;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[5] = 32'h8040FF12;

        // reset state
        #12;
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_ready", 32'(ready), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_mem_din", mem_din, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // lw word 5
        run_op(1'b0, 1'b0, 10'h014, 32'h0);
        chk("lw_lat", 32'(lat), 32'd3);
        chk("lw_rdata", rdata, 32'h8040FF12);
        chk("lw_we_n", 32'(we_n), 32'd0);
        chk("lw_busy_n", 32'(busy_n), 32'd3);

        // lb at each lane
        run_op(1'b0, 1'b1, 10'h015, 32'h0);
        chk("lb15_lat", 32'(lat), 32'd3);
        chk("lb15_rdata", rdata, 32'hFFFFFFFF);
        chk("lb15_we_n", 32'(we_n), 32'd0);
        run_op(1'b0, 1'b1, 10'h016, 32'h0);
        chk("lb16_rdata", rdata, 32'h00000040);
        run_op(1'b0, 1'b1, 10'h017, 32'h0);
        chk("lb17_rdata", rdata, 32'hFFFFFF80);
        run_op(1'b0, 1'b1, 10'h014, 32'h0);
        chk("lb14_rdata", rdata, 32'h00000012);

        // sb lane 2 (read-modify-write)
        run_op(1'b1, 1'b1, 10'h016, 32'h123456AB);
        chk("sb_lat", 32'(lat), 32'd4);
        chk("sb_we_n", 32'(we_n), 32'd1);
        chk("sb_we_addr", we_addr, 32'd5);
        chk("sb_we_din", we_din, 32'h80ABFF12);
        chk("sb_rdata_kept", rdata, 32'h00000012);
        run_op(1'b0, 1'b0, 10'h014, 32'h0);
        chk("sb_lw_rdata", rdata, 32'h80ABFF12);

        // misaligned sw
        run_op(1'b1, 1'b0, 10'h01B, 32'hDEADBEEF);
        chk("sw_lat", 32'(lat), 32'd2);
        chk("sw_we_n", 32'(we_n), 32'd1);
        chk("sw_we_addr", we_addr, 32'd6);
        chk("sw_we_din", we_din, 32'hDEADBEEF);
        chk("sw_rdata_kept", rdata, 32'h80ABFF12);
        run_op(1'b0, 1'b0, 10'h018, 32'h0);
        chk("sw_lw_rdata", rdata, 32'hDEADBEEF);

        // reset during CAP of an sb
        @(negedge clk);
        req = 1'b1; we = 1'b1; lb = 1'b1; addr = 10'h017; wdata = 32'h00000055;
        @(posedge clk);
        #1;
        req = 1'b0;
        @(negedge clk);                 // RD
        @(negedge clk);                 // CAP
        rst = 1'b1;
        #1;
        chk("mrst_busy", 32'(busy), 32'h0);
        chk("mrst_ready", 32'(ready), 32'h0);
        chk("mrst_mem_we", 32'(mem_we), 32'h0);
        chk("mrst_rdata", rdata, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_word5", mem[5], 32'h80ABFF12);
        run_op(1'b0, 1'b0, 10'h014, 32'h0);
        chk("mrst_lw_lat", 32'(lat), 32'd3);
        chk("mrst_lw_rdata", rdata, 32'h80ABFF12);

        // req held high: lw word 5 then lw word 6, garbage addr while busy
        @(negedge clk);
        req = 1'b1; we = 1'b0; lb = 1'b0; addr = 10'h014;
        for (int c = 1; c <= 8; c++) begin
            logic [7:0] e_rdy;
            logic [7:0] e_busy;
            e_rdy  = 8'b0100_0100;      // bit c-1: ready in cycles 3 and 7
            e_busy = 8'b0111_0111;      // idle in cycles 4 and 8
            @(negedge clk);
            chk($sformatf("hold_ready_c%0d", c), 32'(ready), 32'(e_rdy[c-1]));
            chk($sformatf("hold_busy_c%0d", c), 32'(busy), 32'(e_busy[c-1]));
            chk($sformatf("hold_maddr_c%0d", c), 32'(mem_addr), (c <= 4) ? 32'd5 : 32'd6);
            if (c == 3) chk("hold_rdata1", rdata, 32'h80ABFF12);
            if (c == 7) chk("hold_rdata2", rdata, 32'hDEADBEEF);
            if (c == 4)      addr = 10'h018;
            else if (c == 7) req = 1'b0;
            else             addr = 10'h3FC;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
